// File: rtl/mbus_member_req_sched.sv
// Wakes the MBus member controller on local demand, grants requesters
// round-robin, and requests sleep after a quiet idle period.
module mbus_member_req_sched #(
   parameter int NUM_REQ      = 4,
   parameter int IDLE_CYCLES  = 16,
   parameter int WAKE_TIMEOUT = 255
) (
   input  logic               CLK,
   input  logic               RESETn,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [NUM_REQ-1:0] DONE,
   output logic [NUM_REQ-1:0] GNT,
   input  logic               MBC_ISOLATE,
   input  logic               MBC_RESET,
   input  logic               MBUS_BUSY,
   output logic               WAKEUP_REQ,
   output logic               SLEEP_REQ,
   output logic               WAKE_ERR,
   output logic               SCHED_ACTIVE
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      ASLEEP, WAKE, ARB, GRANT, IDLE, SLEEPREQ
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               wakeup_q, wakeup_d;
   logic               sleep_q, sleep_d;
   logic               err_q, err_d;
   logic [PW-1:0]      rr_q, rr_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [7:0]         idle_q, idle_d;
   logic [7:0]         wake_q, wake_d;

   logic                 awake;
   logic [2*NUM_REQ-1:0] req_rot;
   logic                 pick_found;
   logic [PW-1:0]        pick_off;
   logic [PW:0]          pick_sum;
   logic [PW-1:0]        pick_idx;
   logic [PW:0]          own_nxt;
   logic [PW-1:0]        rr_next;

   assign awake   = ~MBC_ISOLATE & ~MBC_RESET;
   assign req_rot = {REQ, REQ} >> rr_q;

   // Rotate so bit 0 is rr_q, take the lowest set bit, un-rotate.
   always_comb begin
      pick_found = 1'b0;
      pick_off   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_rot[k]) begin
            pick_found = 1'b1;
            pick_off   = PW'(k);
         end
      end
      pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
      if (pick_sum >= (PW+1)'(NUM_REQ)) begin
         pick_sum = pick_sum - (PW+1)'(NUM_REQ);
      end
      pick_idx = pick_sum[PW-1:0];
      own_nxt  = {1'b0, owner_q} + (PW+1)'(1);
      if (own_nxt >= (PW+1)'(NUM_REQ)) begin
         own_nxt = '0;
      end
      rr_next = own_nxt[PW-1:0];
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      wakeup_d = wakeup_q;
      sleep_d  = sleep_q;
      err_d    = 1'b0;
      rr_d     = rr_q;
      owner_d  = owner_q;
      idle_d   = idle_q;
      wake_d   = wake_q;
      unique case (state_q)
         ASLEEP: begin
            if (awake) begin
               state_d = IDLE;
               idle_d  = '0;
            end else if (|REQ) begin
               state_d  = WAKE;
               wakeup_d = 1'b1;
               wake_d   = '0;
            end
         end
         WAKE: begin
            if (wake_q != 8'hFF) wake_d = wake_q + 8'd1;
            if (awake) begin
               state_d  = ARB;
               wakeup_d = 1'b0;
            end else if (wake_q == 8'(WAKE_TIMEOUT)) begin
               state_d  = ASLEEP;
               wakeup_d = 1'b0;
               err_d    = 1'b1;
            end
         end
         ARB: begin
            if (!awake) begin
               state_d = ASLEEP;
            end else if (MBUS_BUSY) begin
               state_d = ARB;
            end else if (pick_found) begin
               state_d = GRANT;
               owner_d = pick_idx;
               gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            end else begin
               state_d = IDLE;
               idle_d  = '0;
            end
         end
         GRANT: begin
            if (MBC_ISOLATE) begin
               state_d = ASLEEP;
               gnt_d   = '0;
            end else if (DONE[owner_q] || !REQ[owner_q]) begin
               state_d = ARB;
               gnt_d   = '0;
               rr_d    = rr_next;
            end
         end
         IDLE: begin
            if (MBC_ISOLATE) begin
               state_d = ASLEEP;
            end else if (|REQ) begin
               state_d = ARB;
            end else if (MBUS_BUSY) begin
               idle_d = '0;
            end else if (idle_q == 8'(IDLE_CYCLES-1)) begin
               state_d = SLEEPREQ;
               sleep_d = 1'b1;
            end else if (idle_q != 8'hFF) begin
               idle_d = idle_q + 8'd1;
            end
         end
         SLEEPREQ: begin
            if (MBC_ISOLATE) begin
               state_d = ASLEEP;
               sleep_d = 1'b0;
            end
         end
         default: begin
            state_d  = ASLEEP;
            gnt_d    = '0;
            wakeup_d = 1'b0;
            sleep_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= ASLEEP;
         gnt_q    <= '0;
         wakeup_q <= 1'b0;
         sleep_q  <= 1'b0;
         err_q    <= 1'b0;
         rr_q     <= '0;
         owner_q  <= '0;
         idle_q   <= '0;
         wake_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         wakeup_q <= wakeup_d;
         sleep_q  <= sleep_d;
         err_q    <= err_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         idle_q   <= idle_d;
         wake_q   <= wake_d;
      end
   end

   assign GNT          = gnt_q;
   assign WAKEUP_REQ   = wakeup_q;
   assign SLEEP_REQ    = sleep_q;
   assign WAKE_ERR     = err_q;
   assign SCHED_ACTIVE = (state_q != ASLEEP);

endmodule
